// File: rtl/frame_deframer_p_if.sv
// Frame output stream between the deframer and the per-channel FIFO writer.
//   frame_data  : payload image, word 0 in the low bits, unused words zero
//   frame_ch    : channel field
//   frame_len   : number of payload words
//   frame_valid : a good frame is presented
//   frame_ready : downstream accepts the frame (transfer on valid & ready)
// The master modport is the deframer side; the slave modport is the consumer.
interface frame_deframer_p_if #(
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned CH_W      = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);

  logic [MAX_WORDS*DW-1:0] frame_data;
  logic [CH_W-1:0]         frame_ch;
  logic [LEN_W-1:0]        frame_len;
  logic                    frame_valid;
  logic                    frame_ready;

  modport master (
    output frame_data,
    output frame_ch,
    output frame_len,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_ch,
    input  frame_len,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/frame_deframer_p.sv
// Frame deframer: hunts for a two-word header, captures a channel word and a
// variable-length payload terminated by a two-word tail, and checks the last
// word before the tail against an internal CRC-16 of the preceding words.
// Only good frames reach the one-deep output buffer.
//
// Ports:
//   clk_in    : system clock
//   rst       : synchronous reset, active high
//   in_data   : input word
//   in_valid  : in_data valid this cycle (no backpressure)
//   out_if    : frame output stream (frame_data/ch/len/valid/ready)
//   crc_err   : one-cycle pulse, frame complete but CRC mismatched
//   len_err   : one-cycle pulse, payload length zero or overflowed
//   drop      : one-cycle pulse, good frame lost because the buffer was full
//
// Optional build macro FRAME_STATS_EN adds saturating 16-bit event counters
// stat_good, stat_crc_err, stat_len_err and stat_drop.
module frame_deframer_p #(
  parameter int unsigned    DW          = 16,
  parameter int unsigned    MAX_WORDS   = 8,
  parameter int unsigned    CH_W        = 8,
  parameter logic [DW-1:0]  HEADER_WORD = 16'hE0E0,
  parameter logic [DW-1:0]  TAIL_WORD   = 16'h0E0E,
  parameter logic [15:0]    CRC_POLY    = 16'h1021,
  parameter logic [15:0]    CRC_INIT    = 16'hFFFF
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  frame_deframer_p_if.master  out_if,
  output logic                crc_err,
  output logic                len_err,
  output logic                drop
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0]         stat_good,
  output logic [15:0]         stat_crc_err,
  output logic [15:0]         stat_len_err,
  output logic [15:0]         stat_drop
`endif
);

  localparam int unsigned LEN_W = $clog2(MAX_WORDS + 1);
  // Stored word count reaches MAX_WORDS+1 (payload plus CRC word).
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 2);

  typedef enum logic [2:0] {StIdle, StHdr2, StChan, StData, StTail2} state_e;

  state_e                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [15:0]             crc_q;
  logic [MAX_WORDS*DW-1:0] buf_q;
  logic [DW-1:0]           last_q;
  logic                    done_q;

  logic [MAX_WORDS*DW-1:0] fdata_q;
  logic [CH_W-1:0]         fch_q;
  logic [LEN_W-1:0]        flen_q;
  logic                    fvalid_q;
  logic                    crc_err_q;
  logic                    len_err_q;
  logic                    drop_q;

  logic [MAX_WORDS*DW-1:0] image;
  logic                    crc_ok;
  logic                    xfer;

  // One DW-bit word folded MSB first into the running CRC.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [DW-1:0] word);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  // Payload image: only the first cnt_q-1 words; the CRC word and stale
  // words from earlier frames are masked to zero.
  always_comb begin
    image = '0;
    for (int i = 0; i < int'(MAX_WORDS); i++) begin
      if (CNT_W'(i + 1) < cnt_q) image[i*DW +: DW] = buf_q[i*DW +: DW];
    end
  end

  assign crc_ok = ({{DW{1'b0}}, crc_q} == {16'h0000, last_q});
  assign xfer   = fvalid_q & out_if.frame_ready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      buf_q     <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
      fdata_q   <= '0;
      fch_q     <= '0;
      flen_q    <= '0;
      fvalid_q  <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      drop_q    <= 1'b0;
      done_q    <= 1'b0;

      if (xfer) fvalid_q <= 1'b0;

      // Frame verdict one cycle after the second tail word. The next frame
      // cannot touch cnt_q/crc_q/buf_q before its channel word, so they are
      // still intact here.
      if (done_q) begin
        if (cnt_q < CNT_W'(2)) begin
          len_err_q <= 1'b1;
        end else if (!crc_ok) begin
          crc_err_q <= 1'b1;
        end else if (fvalid_q && !out_if.frame_ready) begin
          drop_q <= 1'b1;
        end else begin
          // Overrides the xfer clear above: back-to-back load, no bubble.
          fvalid_q <= 1'b1;
          fdata_q  <= image;
          fch_q    <= ch_q;
          flen_q   <= LEN_W'(cnt_q - CNT_W'(1));
        end
      end

      if (in_valid) begin
        unique case (state_q)
          StIdle: begin
            if (in_data == HEADER_WORD) state_q <= StHdr2;
          end
          StHdr2: begin
            state_q <= (in_data == HEADER_WORD) ? StChan : StIdle;
          end
          StChan: begin
            ch_q    <= in_data[CH_W-1:0];
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            state_q <= StData;
          end
          StData: begin
            if (in_data == TAIL_WORD) begin
              state_q <= StTail2;
            end else if (cnt_q == CNT_W'(MAX_WORDS + 1)) begin
              len_err_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              for (int i = 0; i < int'(MAX_WORDS); i++) begin
                if (cnt_q == CNT_W'(i)) buf_q[i*DW +: DW] <= in_data;
              end
              // The newest word stays out of the CRC: it may be the CRC word.
              if (cnt_q != '0) crc_q <= crc_step(crc_q, last_q);
              last_q <= in_data;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
          StTail2: begin
            if (in_data == TAIL_WORD) done_q <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign out_if.frame_data  = fdata_q;
  assign out_if.frame_ch    = fch_q;
  assign out_if.frame_len   = flen_q;
  assign out_if.frame_valid = fvalid_q;
  assign crc_err            = crc_err_q;
  assign len_err            = len_err_q;
  assign drop               = drop_q;

`ifdef FRAME_STATS_EN
  logic [15:0] st_good_q;
  logic [15:0] st_crc_q;
  logic [15:0] st_len_q;
  logic [15:0] st_drop_q;
  logic        load_ev;

  assign load_ev = done_q && (cnt_q >= CNT_W'(2)) && crc_ok
                   && !(fvalid_q && !out_if.frame_ready);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      st_good_q <= '0;
      st_crc_q  <= '0;
      st_len_q  <= '0;
      st_drop_q <= '0;
    end else begin
      if (load_ev && st_good_q != 16'hFFFF) st_good_q <= st_good_q + 16'd1;
      if (crc_err_q && st_crc_q != 16'hFFFF) st_crc_q <= st_crc_q + 16'd1;
      if (len_err_q && st_len_q != 16'hFFFF) st_len_q <= st_len_q + 16'd1;
      if (drop_q && st_drop_q != 16'hFFFF) st_drop_q <= st_drop_q + 16'd1;
    end
  end

  assign stat_good    = st_good_q;
  assign stat_crc_err = st_crc_q;
  assign stat_len_err = st_len_q;
  assign stat_drop    = st_drop_q;
`endif

endmodule

// File: tb/tb_frame_deframer_p.sv
module tb_frame_deframer_p;
  localparam int unsigned DW  = 16;
  localparam int unsigned MW  = 8;
  localparam int unsigned CHW = 8;
  localparam int unsigned LW  = $clog2(MW + 1);
  localparam logic [15:0] HDR  = 16'hE0E0;
  localparam logic [15:0] TAIL = 16'h0E0E;

  logic           clk_in = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           frame_ready = 1'b1;
  logic           crc_err;
  logic           len_err;
  logic           drop;
`ifdef FRAME_STATS_EN
  logic [15:0]    stat_good;
  logic [15:0]    stat_crc_err;
  logic [15:0]    stat_len_err;
  logic [15:0]    stat_drop;
`endif

  frame_deframer_p_if #(.DW(DW), .MAX_WORDS(MW), .CH_W(CHW)) fif ();
  assign fif.frame_ready = frame_ready;

  frame_deframer_p #(
    .DW(DW), .MAX_WORDS(MW), .CH_W(CHW),
    .HEADER_WORD(HDR), .TAIL_WORD(TAIL),
    .CRC_POLY(16'h1021), .CRC_INIT(16'h0000)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_if   (fif),
    .crc_err  (crc_err),
    .len_err  (len_err),
    .drop     (drop)
`ifdef FRAME_STATS_EN
    ,
    .stat_good    (stat_good),
    .stat_crc_err (stat_crc_err),
    .stat_len_err (stat_len_err),
    .stat_drop    (stat_drop)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC-16 over the first n words, bit serial, MSB first, seed 0.
  function automatic logic [15:0] crc16(input logic [15:0] ws[$], input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int k = 0; k < n; k++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = c[15] ^ ws[k][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Behavioural model: word-level parser with whole-frame evaluation.
  bit             started = 0;
  int             m_phase;      // 0 hunt, 1 second header, 2 channel, 3 body, 4 second tail
  logic [15:0]    m_words[$];
  logic [7:0]     m_ch;
  bit             m_pend;
  logic [15:0]    p_words[$];
  logic [7:0]     p_ch;
  bit             e_valid;
  logic [127:0]   e_data;
  logic [7:0]     e_ch;
  logic [LW-1:0]  e_len;
  bit             e_crc_err, e_len_err, e_drop;

  always @(posedge clk_in) begin
    bit old_valid;
    int n;
    if (rst) begin
      started = 1;
      m_phase = 0;
      m_words.delete();
      m_pend = 0;
      e_valid = 0; e_data = '0; e_ch = '0; e_len = '0;
      e_crc_err = 0; e_len_err = 0; e_drop = 0;
    end else begin
      e_crc_err = 0; e_len_err = 0; e_drop = 0;
      old_valid = e_valid;
      if (e_valid && frame_ready) e_valid = 0;
      if (m_pend) begin
        m_pend = 0;
        n = p_words.size();
        if (n < 2) e_len_err = 1;
        else if (crc16(p_words, n - 1) != p_words[n-1]) e_crc_err = 1;
        else if (old_valid && !frame_ready) e_drop = 1;
        else begin
          e_valid = 1;
          e_data  = '0;
          for (int i = 0; i < n - 1; i++) e_data[i*16 +: 16] = p_words[i];
          e_ch  = p_ch;
          e_len = LW'(n - 1);
        end
      end
      if (in_valid) begin
        case (m_phase)
          0: if (in_data == HDR) m_phase = 1;
          1: m_phase = (in_data == HDR) ? 2 : 0;
          2: begin m_ch = in_data[7:0]; m_words.delete(); m_phase = 3; end
          3: begin
            if (in_data == TAIL) m_phase = 4;
            else if (m_words.size() == MW + 1) begin e_len_err = 1; m_phase = 0; end
            else m_words.push_back(in_data);
          end
          default: begin
            if (in_data == TAIL) begin m_pend = 1; p_words = m_words; p_ch = m_ch; end
            m_phase = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle compare plus logs of what actually left the DUT.
  logic [127:0] rx_data[$];
  logic [7:0]   rx_ch[$];
  logic [LW-1:0] rx_len[$];
  int n_crc = 0, n_len = 0, n_drop = 0;

  always @(negedge clk_in) begin
    if (started) begin
      check("frame_valid", 128'(fif.frame_valid), 128'(e_valid));
      check("crc_err", 128'(crc_err), 128'(e_crc_err));
      check("len_err", 128'(len_err), 128'(e_len_err));
      check("drop", 128'(drop), 128'(e_drop));
      if (e_valid) begin
        check("frame_data", fif.frame_data, e_data);
        check("frame_ch", 128'(fif.frame_ch), 128'(e_ch));
        check("frame_len", 128'(fif.frame_len), 128'(e_len));
      end
      if (fif.frame_valid && frame_ready) begin
        rx_data.push_back(fif.frame_data);
        rx_ch.push_back(fif.frame_ch);
        rx_len.push_back(fif.frame_len);
      end
      if (crc_err) n_crc++;
      if (len_err) n_len++;
      if (drop) n_drop++;
    end
  end

  task automatic send(input logic [15:0] w, input int gap);
    repeat (gap) begin
      @(posedge clk_in); #1;
      in_valid = 1'b0;
    end
    @(posedge clk_in); #1;
    in_valid = 1'b1;
    in_data  = w;
  endtask

  task automatic send_seq(input logic [15:0] ws[$], input int gap);
    foreach (ws[i]) send(ws[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      in_valid = 1'b0;
    end
  endtask

  logic [15:0] good1[$] = '{16'hE0E0, 16'hE0E0, 16'h0005, 16'h0001, 16'h1021, 16'h0E0E, 16'h0E0E};

  initial begin
    int base;
    logic [15:0] seq[$];

    // Reset
    idle(3);
    @(posedge clk_in); #1; rst = 1'b0;
    @(negedge clk_in);
    check("rst_valid", 128'(fif.frame_valid), 128'd0);
    check("rst_data", fif.frame_data, 128'd0);
    check("rst_len", 128'(fif.frame_len), 128'd0);

    // Good frame with latency pinned: tail at edge N, valid after N+1
    send_seq(good1, 0);
    @(posedge clk_in); #1; in_valid = 1'b0;
    @(negedge clk_in);
    check("lat_n", 128'(fif.frame_valid), 128'd0);
    @(negedge clk_in);
    check("lat_n1", 128'(fif.frame_valid), 128'd1);
    idle(3);
    check("g1_count", 128'(rx_data.size()), 128'd1);
    if (rx_data.size() >= 1) begin
      check("g1_ch", 128'(rx_ch[0]), 128'h05);
      check("g1_len", 128'(rx_len[0]), 128'd1);
      check("g1_data", rx_data[0], 128'h1);
    end

    // Two-word frame, good then bad CRC
    seq = '{16'hE0E0, 16'hE0E0, 16'h0006, 16'h0001, 16'h0000, 16'h3730, 16'h0E0E, 16'h0E0E};
    send_seq(seq, 0); idle(4);
    check("g2_count", 128'(rx_data.size()), 128'd2);
    if (rx_data.size() >= 2) begin
      check("g2_len", 128'(rx_len[1]), 128'd2);
      check("g2_data", rx_data[1], 128'h0000_0001);
    end
    seq[5] = 16'h3731;
    send_seq(seq, 0); idle(4);
    check("bad_crc_pulse", 128'(n_crc), 128'd1);
    check("bad_crc_nofrm", 128'(rx_data.size()), 128'd2);

    // Backpressure: two good frames back-to-back, second dropped
    frame_ready = 1'b0;
    seq = '{16'hE0E0, 16'hE0E0, 16'h0001, 16'h0001, 16'h1021, 16'h0E0E, 16'h0E0E,
            16'hE0E0, 16'hE0E0, 16'h0002, 16'h0001, 16'h1021, 16'h0E0E, 16'h0E0E};
    send_seq(seq, 0); idle(4);
    check("bp_drop", 128'(n_drop), 128'd1);
    check("bp_hold_valid", 128'(fif.frame_valid), 128'd1);
    check("bp_hold_ch", 128'(fif.frame_ch), 128'h01);
    check("bp_hold_data", fif.frame_data, 128'h1);
    @(posedge clk_in); #1; frame_ready = 1'b1;
    idle(3);
    check("bp_count", 128'(rx_data.size()), 128'd3);
    if (rx_data.size() >= 3) check("bp_rx_ch", 128'(rx_ch[2]), 128'h01);

    // Overflow: MW+2 non-tail words
    seq = '{16'hE0E0, 16'hE0E0, 16'h0007};
    for (int i = 0; i < MW + 2; i++) seq.push_back(16'h0100 + 16'(i));
    send_seq(seq, 0); idle(4);
    check("ovf_len_err", 128'(n_len), 128'd1);
    // Only the CRC word before the tail
    seq = '{16'hE0E0, 16'hE0E0, 16'h0003, 16'h1021, 16'h0E0E, 16'h0E0E};
    send_seq(seq, 0); idle(4);
    check("short_len_err", 128'(n_len), 128'd2);
    check("err_nofrm", 128'(rx_data.size()), 128'd3);

    // Broken header, then gapped good frame
    seq = '{16'hE0E0, 16'h1234};
    send_seq(seq, 0); idle(3);
    check("hdr_nofrm", 128'(rx_data.size()), 128'd3);
    send_seq(good1, 2); idle(4);
    check("gap_count", 128'(rx_data.size()), 128'd4);
    if (rx_data.size() >= 4) begin
      check("gap_ch", 128'(rx_ch[3]), 128'h05);
      check("gap_data", rx_data[3], 128'h1);
    end

    // Reset mid-payload, then a clean frame
    seq = '{16'hE0E0, 16'hE0E0, 16'h0008, 16'h0AAA, 16'h0BBB};
    send_seq(seq, 0);
    @(posedge clk_in); #1; in_valid = 1'b0; rst = 1'b1;
    @(posedge clk_in); #1; rst = 1'b0;
    base = rx_data.size();
    send_seq(good1, 0); idle(4);
    check("rst_mid_count", 128'(rx_data.size() - base), 128'd1);
    if (rx_data.size() == base + 1) check("rst_mid_ch", 128'(rx_ch[base]), 128'h05);
    check("pulse_totals", 128'({n_crc, n_len, n_drop}), {32'd1, 32'd2, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_deframer_p.md
Name: frame_deframer_p

Overview:
- Parametrised successor to the front-end frame parser.
- Hunts for a two-word header, captures a channel word and a variable-length payload, and checks the trailing CRC word with an internal word-parallel CRC-16. The external CRC handshake is dropped.
- Only good frames are presented downstream on a valid/ready interface through a one-deep output buffer.
- Sits between the serial word input and the per-channel FIFO writer.

Parameters:
- DW, 16, input word width in bits.
- MAX_WORDS, 8, maximum payload words per frame (CRC word excluded); must be ≥1.
- CH_W, 8, channel field width, taken from the channel word bits [CH_W-1:0].
- HEADER_WORD, 16'hE0E0, header word value.
- TAIL_WORD, 16'h0E0E, tail word value.
- CRC_POLY, 16'h1021, CRC-16 polynomial.
- CRC_INIT, 16'hFFFF, CRC seed.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DW  input word.
- in_valid  in  1  in_data is a valid word this cycle; no backpressure.
- frame_data  out  MAX_WORDS*DW  payload; word 0 in bits [DW-1:0], unused upper words are zero.
- frame_ch  out  CH_W  channel field.
- frame_len  out  $clog2(MAX_WORDS+1)  number of payload words.
- frame_valid  out  1  output buffer holds a good frame.
- frame_ready  in  1  downstream accepts the frame.
- crc_err  out  1  one-cycle pulse: frame completed but CRC mismatched.
- len_err  out  1  one-cycle pulse: payload length was 0 or overflowed.
- drop  out  1  one-cycle pulse: good frame discarded because the buffer was full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: frame_data, frame_ch, frame_len, frame_valid, crc_err, len_err, drop.
  - All counters and the CRC register are cleared. A frame in progress is abandoned.
- in_valid=0 cycles: state, counters and CRC hold.
- FSM, advancing only on in_valid=1:
  - IDLE: word==HEADER_WORD → HDR2.
  - HDR2: word==HEADER_WORD → CHAN; otherwise → IDLE.
  - CHAN: latch word[CH_W-1:0]; clear word count; load crc_run=CRC_INIT; → DATA.
  - DATA, word==TAIL_WORD → TAIL2.
  - DATA, any other word:
    - If word count == MAX_WORDS+1: pulse len_err, → IDLE.
    - Otherwise: store the word at index count, increment count, fold the previous stored word into crc_run. The most recent word is therefore never in the CRC.
  - TAIL2, word==TAIL_WORD, evaluated in this order:
    - count<2 (no payload): pulse len_err.
    - crc_run != last stored word: pulse crc_err.
    - Output buffer full and not accepted this cycle: pulse drop.
    - Otherwise: load the buffer.
    - In every case → IDLE.
  - TAIL2, any other word: → IDLE silently (no error pulse).
- Payload and length: frame_len = count-1. The CRC word is not part of frame_data and is zeroed in the loaded image.
- CRC: CRC-16 over payload words in arrival order, MSB first, no reflection, no final XOR. One word is folded per cycle by a combinational DW-bit step.
- Latency: the second tail word accepted at edge N gives frame_valid=1 after edge N+1. Error pulses appear over the same cycle as frame_valid would.
- Handshake:
  - A transfer occurs on frame_valid & frame_ready.
  - frame_data, frame_ch and frame_len stay stable while frame_valid=1 and frame_ready=0.
  - When a transfer and a load happen in the same cycle, the new frame is loaded (no bubble, no drop).
- A header is recognised only in IDLE/HDR2. TAIL_WORD inside the payload always ends the payload.

Optional Feature:
- Macro: FRAME_STATS_EN.
- Defined: adds four 16-bit outputs, stat_good, stat_crc_err, stat_len_err and stat_drop.
  - Each increments on its event (stat_good on buffer load) and saturates at 16'hFFFF.
  - All four are cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- CRC_INIT=0 for all scenarios below.
- Good frame: E0E0,E0E0,0x0005,0x0001,0x1021,0E0E,0E0E with frame_ready=1 → one-cycle frame_valid; frame_ch=0x05, frame_len=1, frame_data[15:0]=0x0001, upper bits 0.
- Two-word frame: payload 0x0001,0x0000, CRC 0x3730 → frame_len=2, frame_data[31:0]=0x0000_0001. Same frame with CRC 0x3731 → crc_err pulse, frame_valid stays 0.
- Backpressure: frame_ready=0 and two good frames back-to-back → first frame held stable, drop pulses on the second; raise frame_ready → first frame transfers.
- Length errors:
  - MAX_WORDS+2 non-tail words after the channel word → len_err, return to IDLE.
  - Frame with only the CRC word before the tail → len_err.
- Robustness:
  - E0E0,1234 → back to IDLE, nothing output.
  - in_valid gaps inserted inside a good frame → identical output.
  - rst asserted mid-payload, then a clean frame → only the clean frame is output.
